// File: rtl/cheb_t_table_writer.sv
// Evaluates T_0(x)..T_{N_TERMS-1}(x) in Q1.15 by the Chebyshev recurrence and
// streams each term with its index to a writable table over a valid/ready port.
`timescale 1ns/1ps

module cheb_t_table_writer #(
    parameter int N_TERMS = 8,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 16
) (
    input  logic              c_clk,
    input  logic              c_rst_n,
    input  logic              c_start,
    input  logic [DATA_W-1:0] i_x,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_address,
    output logic [DATA_W-1:0] o_wr_data,
    input  logic              i_wr_ready
);

    typedef enum logic [2:0] {IDLE, W0, W1, MUL, WR, DONE} state_t;

    // 17-bit internal terms so that exact +1.0 survives between iterations.
    localparam logic signed [16:0] ONE = 17'sd32768;

    state_t                state;
    logic signed [15:0]    x_reg;
    logic signed [16:0]    t_prev;
    logic signed [16:0]    t_curr;
    logic signed [16:0]    t_next;
    logic signed [16:0]    t_calc;
    logic [ADDR_W-1:0]     k;
    logic signed [32:0]    prod;
    logic signed [19:0]    q;
    logic signed [19:0]    r;

    function automatic logic [15:0] sat16(input logic signed [16:0] v);
        return (v == ONE) ? 16'h7FFF : v[15:0];
    endfunction

    // Shifting by 14 rather than 15 folds the factor of two into 2*x*T_k.
    always_comb begin
        prod = 33'(x_reg) * 33'(t_curr);
        q    = 20'(prod >>> 14);
        r    = q - 20'(t_prev);
        if (r > 20'sd32768) begin
            t_calc = ONE;
        end else if (r < -20'sd32768) begin
            t_calc = -ONE;
        end else begin
            t_calc = 17'(r);
        end
    end

    always_ff @(posedge c_clk or negedge c_rst_n) begin
        if (!c_rst_n) begin
            state        <= IDLE;
            x_reg        <= '0;
            t_prev       <= '0;
            t_curr       <= '0;
            t_next       <= '0;
            k            <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_address <= '0;
            o_wr_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (c_start) begin
                        x_reg        <= i_x;
                        t_prev       <= ONE;
                        o_busy       <= 1'b1;
                        o_wr_en      <= 1'b1;
                        o_wr_address <= '0;
                        o_wr_data    <= 16'h7FFF;
                        state        <= W0;
                    end
                end
                W0: begin
                    if (i_wr_ready) begin
                        t_curr       <= {x_reg[15], x_reg};
                        k            <= ADDR_W'(1);
                        o_wr_address <= ADDR_W'(1);
                        o_wr_data    <= x_reg;
                        state        <= W1;
                    end
                end
                W1: begin
                    if (i_wr_ready) begin
                        o_wr_en <= 1'b0;
                        if (N_TERMS == 2) begin
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    t_next       <= t_calc;
                    o_wr_en      <= 1'b1;
                    o_wr_address <= k + ADDR_W'(1);
                    o_wr_data    <= sat16(t_calc);
                    state        <= WR;
                end
                WR: begin
                    if (i_wr_ready) begin
                        t_prev  <= t_curr;
                        t_curr  <= t_next;
                        k       <= k + ADDR_W'(1);
                        o_wr_en <= 1'b0;
                        if (int'(k) + 1 == N_TERMS - 1) begin
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                    o_wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
